cordic_arg_reducer: RTL

Upstream range-reduction stage for the CORDIC trigonometry accelerator. Accepts an IEEE-754 single-precision angle in radians and reduces it modulo π/2. Emits the reduced angle as float32 in [0, π/2), plus a quadrant index and sign flag that the CORDIC stage uses to select and negate sin/cos. A multi-cycle restoring-division datapath gives a fixed latency of 11 cycles per operation, with one operation in flight at a time.

---
 rtl/cordic_arg_reducer_if.sv | 24 ++
 rtl/cordic_arg_reducer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/cordic_arg_reducer_if.sv
// Handshake and result bundle for the CORDIC argument reducer.
// The master drives the angle and consumer ready; the slave returns the reduced result.
interface cordic_arg_reducer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [1:0]  quadrant;
  logic        neg;
  logic        fold;
  logic        invalid;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, result, quadrant, neg, fold, invalid
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, result, quadrant, neg, fold, invalid
  );
endinterface

// File: rtl/cordic_arg_reducer.sv
// Reduces a float32 angle modulo pi/2 with an 8-step restoring divider (11-cycle latency).
// Define CORDIC_ARGRED_FOLD_EN to reflect reduced angles above pi/4 into [0, pi/4].
module cordic_arg_reducer (
  input logic               clk,
  input logic               reset,
  cordic_arg_reducer_if.slave bus
);

  localparam logic [39:0] C_Q = 40'h01_921F_B544;
`ifdef CORDIC_ARGRED_FOLD_EN
  localparam logic [39:0] C_HALF = C_Q >> 1;
`endif

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_DIV, S_PACK, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] din_q;
  logic [39:0] r_q;
  logic [7:0]  quo_q;
  logic [3:0]  idx_q;
  logic        byp_q, inv_q;
  logic [31:0] result_q;
  logic [1:0]  quadrant_q;
  logic        neg_q, fold_q, invalid_q;

  // Unpack classification of the latched angle.
  logic [7:0]        exp_w;
  logic signed [9:0] e_w;
  logic [4:0]        sh_w;
  logic [39:0]       mag_w;
  logic              invalid_w, bypass_w;

  always_comb begin
    exp_w     = din_q[30:23];
    e_w       = $signed({2'b00, exp_w}) - 10'sd127;
    sh_w      = 5'(e_w + 10'sd9);
    mag_w     = {16'd0, 1'b1, din_q[22:0]} << sh_w;
    invalid_w = (exp_w == 8'hFF) || (e_w >= 10'sd8);
`ifdef CORDIC_ARGRED_FOLD_EN
    // Angles in (pi/4, pi/2) leave the pass-through so they can be reflected.
    bypass_w  = (exp_w == 8'h00) || (e_w < -10'sd1) ||
                ((e_w == -10'sd1) && (mag_w <= C_HALF));
`else
    bypass_w  = (exp_w == 8'h00) || (e_w < 10'sd0) || (mag_w < C_Q);
`endif
  end

  // Remainder normalisation back to float32, truncating.
  logic [32:0] val_w;
  logic        fold_w;
  logic [5:0]  p_w;
  logic [22:0] mant_w;
  logic [31:0] packed_w;

  always_comb begin
    fold_w = 1'b0;
    val_w  = r_q[32:0];
`ifdef CORDIC_ARGRED_FOLD_EN
    if (r_q > C_HALF) begin
      fold_w = 1'b1;
      val_w  = 33'(C_Q - r_q);
    end
`endif
    p_w = 6'd0;
    for (int k = 0; k < 33; k++) begin
      if (val_w[k]) p_w = 6'(k);
    end
    mant_w   = 23'((val_w[31:0] << (6'd32 - p_w)) >> 9);
    packed_w = (val_w == 33'd0) ? 32'd0 : {1'b0, {2'b00, p_w} + 8'd95, mant_w};
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.in_valid) state_d = S_UNPACK;
      S_UNPACK: state_d = S_DIV;
      S_DIV:    if (idx_q == 4'd0) state_d = S_PACK;
      S_PACK:   state_d = S_DONE;
      S_DONE:   if (bus.out_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      din_q      <= '0;
      r_q        <= '0;
      quo_q      <= '0;
      idx_q      <= '0;
      byp_q      <= 1'b0;
      inv_q      <= 1'b0;
      result_q   <= '0;
      quadrant_q <= '0;
      neg_q      <= 1'b0;
      fold_q     <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (bus.in_valid) din_q <= bus.data_in;
        S_UNPACK: begin
          inv_q <= invalid_w;
          byp_q <= bypass_w && !invalid_w;
          r_q   <= (invalid_w || bypass_w) ? 40'd0 : mag_w;
          quo_q <= 8'd0;
          idx_q <= 4'd7;
        end
        S_DIV: begin
          if (!byp_q && (r_q >= (C_Q << idx_q))) begin
            r_q               <= r_q - (C_Q << idx_q);
            quo_q[idx_q[2:0]] <= 1'b1;
          end
          idx_q <= idx_q - 4'd1;
        end
        S_PACK: begin
          neg_q <= din_q[31];
          if (inv_q) begin
            result_q   <= 32'h7FC0_0000;
            quadrant_q <= 2'd0;
            fold_q     <= 1'b0;
            invalid_q  <= 1'b1;
          end else if (byp_q) begin
            result_q   <= {1'b0, din_q[30:0]};
            quadrant_q <= 2'd0;
            fold_q     <= 1'b0;
            invalid_q  <= 1'b0;
          end else begin
            result_q   <= packed_w;
            quadrant_q <= quo_q[1:0];
            fold_q     <= fold_w;
            invalid_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.quadrant  = quadrant_q;
  assign bus.neg       = neg_q;
  assign bus.fold      = fold_q;
  assign bus.invalid   = invalid_q;

endmodule
